// File: rtl/nios2_led_sequencer_if.sv
// Avalon-MM bundle for the LED sequencer: CSR slave port plus the PIO-facing write master.
// The same instance is bound to both modports of the sequencer.
interface nios2_led_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output m_address, m_write, m_writedata,
    input  m_waitrequest
  );
endinterface

// File: rtl/nios2_led_sequencer.sv
// Autonomous LED pattern sequencer: CSR slave, pattern table, timed writes to the PIO data register.
// Optional LED_SEQ_BLANK_ON_STOP_EN adds a BLANK state that writes 0 to the LEDs before going idle.
//
// Handshakes: the slave accepts a write on any clock with chipselect=1 and write_n=0 (zero wait);
// readdata is combinational from address. The master raises m_write with address/data and holds all
// three unchanged until a clock on which m_waitrequest=0, which completes the transfer.
module nios2_led_sequencer #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int PERIOD_W   = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios2_led_sequencer_if.slave  csr,
  nios2_led_sequencer_if.master mst,
  output logic [2:0]            dbg_state
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3
`ifdef LED_SEQ_BLANK_ON_STOP_EN
    , S_BLANK = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  m_write_q, m_write_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  run_q, run_d;
  logic                  loop_q, loop_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [6:0]            length_q, length_d;
  logic [AW-1:0]         pat_addr_q, pat_addr_d;
  logic [DATA_WIDTH-1:0] table_q [DEPTH];
`ifdef LED_SEQ_BLANK_ON_STOP_EN
  logic                  blank_done_q, blank_done_d;
`endif

  logic csr_wr, ctrl_wr, status_wr, period_wr, length_wr, paddr_wr, pdata_wr;
  logic start, go_idle, go_done, set_done, clr_run, load_issue;
  logic [AW-1:0]       issue_idx;
  logic [6:0]          len_eff;
  logic                is_last;
  logic [PERIOD_W-1:0] cnt_load;
  logic                busy;
  logic [31:0]         rdata;
  logic                unused_wdata;

  assign csr_wr    = csr.chipselect & ~csr.write_n;
  assign ctrl_wr   = csr_wr & (csr.address == 3'd0);
  assign status_wr = csr_wr & (csr.address == 3'd1);
  assign period_wr = csr_wr & (csr.address == 3'd2);
  assign length_wr = csr_wr & (csr.address == 3'd3);
  assign paddr_wr  = csr_wr & (csr.address == 3'd4);
  assign pdata_wr  = csr_wr & (csr.address == 3'd5);
  assign unused_wdata = ^csr.writedata;

  // LENGTH of 0 acts as 1 and anything beyond the table acts as the full table.
  always_comb begin
    if (length_q == 7'd0)         len_eff = 7'd1;
    else if (length_q > DEPTH_L)  len_eff = DEPTH_L;
    else                          len_eff = length_q;
  end

  assign is_last  = (7'(idx_q) >= (len_eff - 7'd1));
  assign cnt_load = (period_q == '0) ? '0 : (period_q - PERIOD_W'(1));
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    m_write_d  = m_write_q;
    m_wdata_d  = m_wdata_q;
    start      = 1'b0;
    go_idle    = 1'b0;
    go_done    = 1'b0;
    set_done   = 1'b0;
    clr_run    = 1'b0;
    load_issue = 1'b0;
    issue_idx  = '0;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
    blank_done_d = blank_done_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && csr.writedata[0]) begin
          start      = 1'b1;
          idx_d      = '0;
          load_issue = 1'b1;
          issue_idx  = '0;
        end
      end
      S_ISSUE: begin
        // A stop request never abandons a transfer that is already on the bus.
        if (!mst.m_waitrequest) begin
          if (!run_q) begin
            go_idle = 1'b1;
          end else begin
            m_write_d = 1'b0;
            cnt_d     = cnt_load;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!run_q)              go_idle = 1'b1;
        else if (cnt_q == '0)    state_d = S_STEP;
        else                     cnt_d   = cnt_q - PERIOD_W'(1);
      end
      S_STEP: begin
        if (!run_q) begin
          go_idle = 1'b1;
        end else if (!is_last) begin
          idx_d      = idx_q + AW'(1);
          load_issue = 1'b1;
          issue_idx  = idx_q + AW'(1);
        end else if (loop_q) begin
          idx_d      = '0;
          load_issue = 1'b1;
          issue_idx  = '0;
        end else begin
          clr_run = 1'b1;
          go_idle = 1'b1;
          go_done = 1'b1;
        end
      end
`ifdef LED_SEQ_BLANK_ON_STOP_EN
      S_BLANK: begin
        if (!mst.m_waitrequest) begin
          m_write_d = 1'b0;
          state_d   = S_IDLE;
          set_done  = blank_done_q;
        end
      end
`endif
      default: begin
        m_write_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Pattern is captured on entry to ISSUE so it stays stable through any stall.
    if (load_issue) begin
      state_d   = S_ISSUE;
      m_write_d = 1'b1;
      m_wdata_d = table_q[issue_idx];
    end

    if (go_idle) begin
`ifdef LED_SEQ_BLANK_ON_STOP_EN
      state_d      = S_BLANK;
      m_write_d    = 1'b1;
      m_wdata_d    = '0;
      blank_done_d = go_done;
`else
      state_d   = S_IDLE;
      m_write_d = 1'b0;
      m_wdata_d = '0;
      set_done  = go_done;
`endif
    end
  end

  always_comb begin
    run_d      = run_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    period_d   = period_q;
    length_d   = length_q;
    pat_addr_d = pat_addr_q;
    if (ctrl_wr) begin
      run_d    = csr.writedata[0];
      loop_d   = csr.writedata[1];
      irq_en_d = csr.writedata[2];
    end
    if (clr_run) run_d = 1'b0;
    // Ordering gives a same-cycle FSM set priority over the W1C clear.
    if (status_wr && csr.writedata[1]) done_d = 1'b0;
    if (start)    done_d = 1'b0;
    if (set_done) done_d = 1'b1;
    if (period_wr) period_d = csr.writedata[PERIOD_W-1:0];
    if (length_wr) length_d = csr.writedata[6:0];
    if (paddr_wr)      pat_addr_d = csr.writedata[AW-1:0];
    else if (pdata_wr) pat_addr_d = pat_addr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      m_write_q  <= 1'b0;
      m_wdata_q  <= '0;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      period_q   <= '0;
      length_q   <= '0;
      pat_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      m_write_q  <= m_write_d;
      m_wdata_q  <= m_wdata_d;
      run_q      <= run_d;
      loop_q     <= loop_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      period_q   <= period_d;
      length_q   <= length_d;
      pat_addr_q <= pat_addr_d;
    end
  end

`ifdef LED_SEQ_BLANK_ON_STOP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blank_done_q <= 1'b0;
    else          blank_done_q <= blank_done_d;
  end
`endif

  // Table storage has no reset; contents are undefined until software loads them.
  always_ff @(posedge clk) begin
    if (pdata_wr) table_q[pat_addr_q] <= csr.writedata[DATA_WIDTH-1:0];
  end

  always_comb begin
    rdata = '0;
    case (csr.address)
      3'd0: rdata[2:0] = {irq_en_q, loop_q, run_q};
      3'd1: begin
        rdata[0]    = busy;
        rdata[1]    = done_q;
        rdata[13:8] = 6'(idx_q);
      end
      3'd2: rdata[PERIOD_W-1:0]   = period_q;
      3'd3: rdata[6:0]            = length_q;
      3'd4: rdata[AW-1:0]         = pat_addr_q;
      3'd5: rdata[DATA_WIDTH-1:0] = table_q[pat_addr_q];
      default: rdata = '0;
    endcase
  end

  assign csr.readdata    = rdata;
  assign csr.irq         = done_q & irq_en_q;
  assign mst.m_address   = 2'b00;
  assign mst.m_write     = m_write_q;
  assign mst.m_writedata = 32'(m_wdata_q);
  assign dbg_state       = 3'(state_q);
endmodule

// File: tb/tb_nios2_led_sequencer.sv
// Self-checking bench for nios2_led_sequencer: directed scenarios plus randomized table/length/period
// runs checked against a sequence-level model (expected writes, spacing, completion time).
module tb_nios2_led_sequencer;
  localparam int DW    = 10;
  localparam int DEPTH = 16;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
  localparam int BLANK_W = 1;
`else
  localparam int BLANK_W = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         stall_en = 1'b0;

  logic [31:0]   mon_data[$];
  int            mon_cyc[$];
  logic [31:0]   exp_q[$];
  logic [DW-1:0] tbl_m [DEPTH];

  nios2_led_sequencer_if bus();

  nios2_led_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .csr(bus), .mst(bus), .dbg_state(dbg_state)
  );

  // clock / reset / monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (reset_n && bus.m_write && !bus.m_waitrequest) begin
      mon_data.push_back(bus.m_writedata);
      mon_cyc.push_back(cyc);
    end
  always @(posedge clk)
    if (stall_en) begin
      #1 bus.m_waitrequest = ($urandom_range(0, 2) == 0);
    end

  // driver tasks
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; #1;
    d = bus.readdata;
  endtask

  task automatic load_table(input int n);
    csr_wr(3'd4, 32'd0);
    for (int i = 0; i < n; i++) csr_wr(3'd5, 32'(tbl_m[i]));
  endtask

  task automatic wait_idle(input int budget, output int hit, output bit ok);
    ok = 1'b0; hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      bus.address = 3'd1; #1;
      if (!bus.readdata[0]) begin
        hit = cyc; ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic int len_model(input int len_raw);
    if (len_raw == 0) return 1;
    if (len_raw > DEPTH) return DEPTH;
    return len_raw;
  endfunction

  // scenarios
  task automatic test_reset();
    logic [31:0] r;
    for (int a = 0; a < 8; a++) begin
      if (a != 5) begin
        csr_rd(3'(a), r);
        n_tests++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_csr%0d: got %0h expected 0", a, r); end
      end
    end
    n_tests++;
    if (bus.m_write !== 1'b0 || bus.m_writedata !== 32'd0 || bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: m_write=%b m_writedata=%0h irq=%b expected 0", bus.m_write, bus.m_writedata, bus.irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] r; int t; bit ok;
    tbl_m[0] = 10'h001; tbl_m[1] = 10'h002; tbl_m[2] = 10'h004;
    load_table(3);
    csr_wr(3'd3, 32'd3); csr_wr(3'd2, 32'd4);
    mon_data.delete(); mon_cyc.delete();
    csr_wr(3'd0, 32'h5);
    wait_idle(200, t, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL oneshot_timeout: busy still 1 after 200 clks"); end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(tbl_m[i]));
    if (BLANK_W != 0) exp_q.push_back(32'd0);
    n_tests++;
    if (mon_data.size() != exp_q.size()) begin
      n_fail++; $display("FAIL oneshot_count: got %0d writes expected %0d", mon_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (mon_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL oneshot_data%0d: got %0h expected %0h", i, mon_data[i], exp_q[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (mon_cyc[i] - mon_cyc[i-1] != 6) begin n_fail++; $display("FAIL oneshot_spacing%0d: got %0d expected 6", i, mon_cyc[i] - mon_cyc[i-1]); end
      end
      n_tests++;
      if (t != mon_cyc[2] + 6 + BLANK_W) begin n_fail++; $display("FAIL oneshot_done_time: got %0d expected %0d", t, mon_cyc[2] + 6 + BLANK_W); end
    end
    csr_rd(3'd1, r);
    n_tests++;
    if (r[1:0] !== 2'b10 || r[13:8] !== 6'd2) begin n_fail++; $display("FAIL oneshot_status: got %0h expected 0x202", r); end
    n_tests++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b expected 1", bus.irq); end
    csr_wr(3'd1, 32'h2);
    @(negedge clk);
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_w1c: got %b expected 0", bus.irq); end
  endtask

  task automatic test_loop();
    logic [31:0] r; int t; bit ok; int n_pat; int n_after;
    mon_data.delete(); mon_cyc.delete();
    csr_wr(3'd0, 32'h3);
    repeat (30) @(posedge clk);
    csr_wr(3'd0, 32'h0);
    wait_idle(3 + 2 * BLANK_W, t, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL loop_stop_latency: busy still 1 after %0d clks", 3 + 2 * BLANK_W); end
    n_after = mon_data.size();
    repeat (10) @(negedge clk);
    n_tests++;
    if (mon_data.size() != n_after) begin n_fail++; $display("FAIL loop_write_after_stop: got %0d writes expected %0d", mon_data.size(), n_after); end
    n_pat = mon_data.size() - BLANK_W;
    n_tests++;
    if (n_pat < 5 || n_pat > 7) begin n_fail++; $display("FAIL loop_count: got %0d pattern writes expected 5..7", n_pat); end
    exp_q.delete();
    for (int i = 0; i < n_pat; i++) exp_q.push_back(32'(tbl_m[i % 3]));
    if (BLANK_W != 0) exp_q.push_back(32'd0);
    for (int i = 0; i < mon_data.size(); i++) begin
      n_tests++;
      if (mon_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL loop_data%0d: got %0h expected %0h", i, mon_data[i], exp_q[i]); end
    end
    for (int i = 1; i < n_pat; i++) begin
      n_tests++;
      if (mon_cyc[i] - mon_cyc[i-1] != 6) begin n_fail++; $display("FAIL loop_spacing%0d: got %0d expected 6", i, mon_cyc[i] - mon_cyc[i-1]); end
    end
    csr_rd(3'd1, r);
    n_tests++;
    if (r[1:0] !== 2'b00) begin n_fail++; $display("FAIL loop_done_clear: got status %0h expected busy=0 done=0", r); end
  endtask

  task automatic test_stall();
    logic [31:0] r; int t; bit ok;
    csr_wr(3'd2, 32'd2);
    mon_data.delete(); mon_cyc.delete();
    bus.m_waitrequest = 1'b1;
    csr_wr(3'd0, 32'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m_write !== 1'b1 || bus.m_writedata !== 32'(tbl_m[0])) begin
        n_fail++; $display("FAIL stall_hold%0d: m_write=%b data=%0h expected 1/%0h", i, bus.m_write, bus.m_writedata, tbl_m[0]);
      end
    end
    csr_wr(3'd0, 32'h0);
    csr_rd(3'd1, r);
    n_tests++;
    if (r[0] !== 1'b1 || bus.m_write !== 1'b1 || mon_data.size() != 0) begin
      n_fail++; $display("FAIL stall_stop_hold: busy=%b m_write=%b writes=%0d expected 1/1/0", r[0], bus.m_write, mon_data.size());
    end
    @(posedge clk); #1 bus.m_waitrequest = 1'b0;
    wait_idle(20, t, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout: busy still 1 after 20 clks"); end
    exp_q.delete();
    exp_q.push_back(32'(tbl_m[0]));
    if (BLANK_W != 0) exp_q.push_back(32'd0);
    n_tests++;
    if (mon_data.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d writes expected %0d", mon_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (mon_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data%0d: got %0h expected %0h", i, mon_data[i], exp_q[i]); end
      end
    end
    csr_rd(3'd1, r);
    n_tests++;
    if (r[1] !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b expected 0", r[1]); end
  endtask

  task automatic test_min_len_period();
    int t; bit ok;
    tbl_m[0] = 10'h3FF;
    load_table(1);
    csr_wr(3'd2, 32'd0); csr_wr(3'd3, 32'd0);
    mon_data.delete(); mon_cyc.delete();
    csr_wr(3'd0, 32'h1);
    wait_idle(50, t, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL min_timeout: busy still 1 after 50 clks"); end
    n_tests++;
    if (mon_data.size() != 1 + BLANK_W) begin
      n_fail++; $display("FAIL min_count: got %0d writes expected %0d", mon_data.size(), 1 + BLANK_W);
    end else begin
      n_tests++;
      if (mon_data[0] !== 32'h3FF) begin n_fail++; $display("FAIL min_data: got %0h expected 3ff", mon_data[0]); end
      n_tests++;
      if (t != mon_cyc[0] + 3 + BLANK_W) begin n_fail++; $display("FAIL min_done_time: got %0d expected %0d", t, mon_cyc[0] + 3 + BLANK_W); end
    end
    csr_wr(3'd1, 32'h2);
  endtask

  task automatic test_pat_addr();
    logic [31:0] r;
    csr_wr(3'd4, 32'd15);
    csr_wr(3'd5, 32'h155);
    csr_wr(3'd5, 32'h2AA);
    csr_rd(3'd4, r);
    n_tests++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL pat_addr_wrap: got %0h expected 1", r); end
    csr_wr(3'd4, 32'd15);
    csr_rd(3'd5, r);
    n_tests++;
    if (r !== 32'h155) begin n_fail++; $display("FAIL pat_data15: got %0h expected 155", r); end
    csr_rd(3'd5, r);
    n_tests++;
    if (r !== 32'h155) begin n_fail++; $display("FAIL pat_data15_reread: got %0h expected 155", r); end
    csr_rd(3'd4, r);
    n_tests++;
    if (r !== 32'd15) begin n_fail++; $display("FAIL pat_addr_no_inc: got %0h expected f", r); end
    csr_wr(3'd4, 32'd0);
    csr_rd(3'd5, r);
    n_tests++;
    if (r !== 32'h2AA) begin n_fail++; $display("FAIL pat_data0: got %0h expected 2aa", r); end
    csr_wr(3'd6, 32'hFFFF_FFFF);
    csr_rd(3'd6, r);
    n_tests++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL reserved_read: got %0h expected 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] r; int t; bit ok; int len_raw, per, leff, peff; bit ien, stall_it;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) tbl_m[i] = DW'($urandom_range(0, (1 << DW) - 1));
      load_table(DEPTH);
      len_raw = $urandom_range(0, 20);
      per = $urandom_range(0, 6);
      ien = 1'($urandom_range(0, 1));
      stall_it = (it >= 4);
      leff = len_model(len_raw);
      peff = (per == 0) ? 1 : per;
      csr_wr(3'd3, 32'(len_raw)); csr_wr(3'd2, 32'(per));
      mon_data.delete(); mon_cyc.delete();
      stall_en = stall_it;
      csr_wr(3'd0, {29'd0, ien, 2'b01});
      wait_idle(2000, t, ok);
      stall_en = 1'b0;
      #2 bus.m_waitrequest = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: busy still 1 after 2000 clks", it); end
      exp_q.delete();
      for (int i = 0; i < leff; i++) exp_q.push_back(32'(tbl_m[i]));
      if (BLANK_W != 0) exp_q.push_back(32'd0);
      n_tests++;
      if (mon_data.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d writes expected %0d (len=%0d)", it, mon_data.size(), exp_q.size(), len_raw);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (mon_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_data%0d: got %0h expected %0h", it, i, mon_data[i], exp_q[i]); end
        end
        if (!stall_it) begin
          for (int i = 1; i < leff; i++) begin
            n_tests++;
            if (mon_cyc[i] - mon_cyc[i-1] != peff + 2) begin
              n_fail++; $display("FAIL rand%0d_spacing%0d: got %0d expected %0d", it, i, mon_cyc[i] - mon_cyc[i-1], peff + 2);
            end
          end
          n_tests++;
          if (t != mon_cyc[leff-1] + peff + 2 + BLANK_W) begin
            n_fail++; $display("FAIL rand%0d_done_time: got %0d expected %0d", it, t, mon_cyc[leff-1] + peff + 2 + BLANK_W);
          end
        end
      end
      csr_rd(3'd1, r);
      n_tests++;
      if (r[1:0] !== 2'b10 || r[13:8] !== 6'(leff - 1)) begin
        n_fail++; $display("FAIL rand%0d_status: got %0h expected done=1 busy=0 idx=%0d", it, r, leff - 1);
      end
      n_tests++;
      if (bus.irq !== ien) begin n_fail++; $display("FAIL rand%0d_irq: got %b expected %b", it, bus.irq, ien); end
      csr_wr(3'd1, 32'h2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int n0;
    for (int i = 0; i < 3; i++) tbl_m[i] = DW'(10'h100 + i);
    load_table(3);
    csr_wr(3'd3, 32'd3);
    bus.m_waitrequest = 1'b1;
    csr_wr(3'd0, 32'h1);
    @(negedge clk);
    n_tests++;
    if (bus.m_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre_issue: m_write=%b expected 1", bus.m_write); end
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.m_write !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: m_write=%b expected 0", bus.m_write); end
    bus.m_waitrequest = 1'b0;
    #20 reset_n = 1'b1;
    csr_wr(3'd2, 32'd40);
    mon_data.delete(); mon_cyc.delete();
    csr_wr(3'd0, 32'h7);
    for (int i = 0; i < 20 && mon_data.size() == 0; i++) @(negedge clk);
    n_tests++;
    if (mon_data.size() == 0) begin n_fail++; $display("FAIL rst_mid_first_write: got 0 writes expected 1"); end
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.m_write !== 1'b0 || bus.irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: m_write=%b irq=%b expected 0/0", bus.m_write, bus.irq); end
    #20 reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      if (a != 5) begin
        csr_rd(3'(a), r);
        n_tests++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL rst_mid_csr%0d: got %0h expected 0", a, r); end
      end
    end
    n0 = mon_data.size();
    repeat (20) @(negedge clk);
    n_tests++;
    if (mon_data.size() != n0 || bus.m_writedata !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_idle: writes %0d->%0d data=%0h expected no writes, data 0", n0, mon_data.size(), bus.m_writedata);
    end
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.writedata = 32'd0; bus.m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    test_reset();
    test_oneshot();
    test_loop();
    test_stall();
    test_min_len_period();
    test_pat_addr();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nios2_led_sequencer.md
Name: nios2_led_sequencer

Overview:
- Autonomous pattern sequencer for the 10-bit LED PIO.
- Holds a small pattern table, steps through it at a programmable rate, and writes each pattern to the PIO data register (s1, offset 0) as an Avalon-MM master.
- Nios II configures it through an Avalon-MM slave CSR window and can take an end-of-sequence interrupt, so LED animations run without CPU involvement.

Parameters:
DATA_WIDTH, 10, LED pattern width; must match the PIO out_port width.
DEPTH, 16, pattern table entries; power of two, 2..64.
PERIOD_W, 24, width of the step-period register/counter.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  CSR word select
chipselect  in  1  slave select
write_n  in  1  active-low slave write strobe
writedata  in  32  slave write data
readdata  out  32  slave read data; zero-wait, combinational from address
m_address  out  2  master address; constant 0 (PIO data register)
m_write  out  1  master write request
m_writedata  out  32  master write data; {zeros, pattern}
m_waitrequest  in  1  interconnect stall
irq  out  1  level interrupt = done & irq_en

Behaviour:
CSR map (word offsets):
- 0 CONTROL: [0] run, [1] loop, [2] irq_en.
- 1 STATUS: [0] busy (RO), [1] done (W1C), [13:8] current index (RO).
- 2 PERIOD: [PERIOD_W-1:0] clocks per step; 0 behaves as 1.
- 3 LENGTH: [6:0] patterns used; 0 behaves as 1, >DEPTH behaves as DEPTH.
- 4 PAT_ADDR: table pointer, log2(DEPTH) bits.
- 5 PAT_DATA: write stores writedata[DATA_WIDTH-1:0] at PAT_ADDR, then PAT_ADDR += 1 modulo DEPTH. Read returns table[PAT_ADDR] without increment.
- 6, 7: read 0; writes ignored.

Reset:
- All CSRs 0; table contents undefined.
- FSM in IDLE; m_write 0, m_writedata 0, irq 0.

FSM:
- IDLE: busy=0. Write to CONTROL with run 0->1 goes to ISSUE, with idx=0 and done cleared.
- ISSUE: m_write=1, m_writedata=table[idx]. Hold address/data/write stable while m_waitrequest=1. On the cycle m_waitrequest=0 the write completes; load counter with max(PERIOD,1)-1 and go to WAIT.
- WAIT: decrement counter each clk; at 0, go to STEP.
- STEP: single cycle.
  - If idx < LEN-1: idx+1 -> ISSUE.
  - Else if loop: idx=0 -> ISSUE.
  - Else: set done, clear run -> IDLE.
- Step-to-step spacing = max(PERIOD,1) + 2 + stall cycles (ISSUE and STEP add 1 clk each).

Boundary conditions:
- Run cleared by the CPU in ISSUE: the in-flight write is completed, never dropped; then IDLE. done not set.
- Run cleared in WAIT or STEP: next cycle goes to IDLE; done not set.
- Run written 1 while already running: no effect; no restart.
- Table or LENGTH written while running: takes effect at the next ISSUE/STEP evaluation.
- PERIOD written while running: takes effect at the next counter load.
- W1C of done in the same cycle the FSM sets it: the set wins.
- LENGTH=1 with loop=1: rewrites table[0] every step.
- reset_n asserted mid-transfer: m_write drops asynchronously; the interconnect tolerates this on reset.

Optional Feature:
LED_SEQ_BLANK_ON_STOP_EN
- Defined: on every transition to IDLE (done or CPU stop), the FSM first passes through state BLANK. BLANK issues one master write of 0 using the same waitrequest rules, so the LEDs are dark when stopped. busy stays 1 until that write completes. done is set after BLANK completes.
- Undefined: BLANK does not exist; the LEDs keep the last pattern written.

Test Plan:
1. Table {0x001,0x002,0x004}, LENGTH=3, PERIOD=4, loop=0, irq_en=1, run=1, m_waitrequest=0 -> master writes 0x001, 0x002, 0x004 spaced 6 clks apart; then busy=0, done=1, irq=1. W1C of STATUS[1] -> irq=0.
2. Same setup but loop=1, run for 30 clks, then write CONTROL=0 -> sequence 1,2,4,1,2 repeats with no gap beyond spacing; stops within 1 clk unless in ISSUE; done stays 0.
3. m_waitrequest held 1 for 5 clks on the first ISSUE -> m_write/m_writedata stable for 6 clks; WAIT begins only after acceptance; then run cleared during the stall -> the write still completes, then IDLE.
4. PERIOD=0, LENGTH=0, table[0]=0x3FF -> one write of 0x3FF, then done after 3 clks.
5. PAT_ADDR=15, two PAT_DATA writes 0x155, 0x2AA -> table[15]=0x155, table[0]=0x2AA, PAT_ADDR reads 1. Reads of PAT_DATA do not increment.
6. reset_n pulsed low mid-WAIT -> m_write=0, irq=0, CSRs read 0, FSM IDLE. With LED_SEQ_BLANK_ON_STOP_EN, test 1 additionally ends with a write of 0x000 before done=1.
